dsram_responder: RTL and testbench
==================================

// Module: dsram_responder
// PURPOSE
//  Synthesizable data-SRAM responder that serves the core's dsram_* request port
//  (e/we/addr/wdata/sel -> rdata). Sits in top beside the fsl core and replaces the
//  DPI mem_read/mem_write data path with on-chip RAM for FPGA/lint builds.
//  Single-port, one request per cycle, synchronous read, byte-masked write.
// PARAMETERS
//  BASE_ADDR    64'h8000_0000  byte address of RAM word 0
//  DEPTH_WORDS  8192           64-bit words of RAM (64 KiB); power of two
//  SERIAL_ADDR  64'hA000_03F8  MMIO serial TX byte register (DSRAM_MMIO_EN only)
//  RTC_ADDR     64'hA000_0048  MMIO free-running cycle counter (DSRAM_MMIO_EN only)
//  FIFO_DEPTH   4              serial TX FIFO entries; power of two
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  dsram_e      in   1   request valid this cycle
//  dsram_we     in   1   1 = write, 0 = read (ignored when dsram_e=0)
//  dsram_addr   in   64  byte address; bits [2:0] ignored, doubleword aligned
//  dsram_wdata  in   64  write data, lane i = bits [8i+7:8i]
//  dsram_sel    in   8   byte-lane write enables
//  dsram_rdata  out  64  read data, valid the cycle after the read request
//  access_err   out  1   one-cycle pulse, cycle after an unmapped access
//  err_sticky   out  1   set by any access_err, cleared only by rst
//  uart_valid   out  1   serial byte available (0 when DSRAM_MMIO_EN undefined)
//  uart_data    out  8   serial byte, FIFO head
//  uart_ready   in   1   sink accepts uart_data when uart_valid && uart_ready
//  uart_ovf     out  1   sticky: serial byte dropped on full FIFO; cleared by rst
// BEHAVIOUR
//  Reset: dsram_rdata=0, access_err=0, err_sticky=0, uart_valid=0, uart_data=0,
//   uart_ovf=0, FIFO empty, RTC counter=0. RAM contents NOT reset.
//  Decode: RAM hit iff BASE_ADDR <= addr < BASE_ADDR+8*DEPTH_WORDS;
//   index = (addr-BASE_ADDR)>>3, full 64-bit compare (no aliasing).
//  Read (e=1,we=0, hit): dsram_rdata <= mem[index] at edge; 1-cycle latency.
//  dsram_rdata holds last value in cycles with no read and during writes.
//  Write (e=1,we=1, hit): lanes with sel[i]=1 updated at edge; rdata unchanged.
//   sel=0 write is a legal no-op (no error).
//  Write in cycle N, read same index cycle N+1 -> returns written data (no hazard).
//  Unmapped access: write dropped, read returns rdata=0; access_err=1 next cycle.
//  Back-to-back requests every cycle fully supported; no stall/ready output.
//  rst asserted mid-sequence: outputs to reset values next edge; pending FIFO lost.
// CONFIGURATION
//  DSRAM_MMIO_EN defined:
//   - write to SERIAL_ADDR with sel[0]=1 pushes wdata[7:0] into TX FIFO; sel[0]=0
//     is a no-op. FIFO full (and no pop same cycle) -> byte dropped, uart_ovf<=1.
//     Full with pop same cycle -> push accepted. Push into empty: uart_valid next
//     cycle (no bypass). Pop when uart_valid && uart_ready; FIFO order preserved.
//   - read SERIAL_ADDR -> {62'b0, fifo_full, fifo_empty}.
//   - read RTC_ADDR -> 64-bit cycle counter (+1 every cycle from reset, wraps
//     2^64-1 -> 0); value sampled in request cycle. Write to RTC_ADDR ignored.
//  DSRAM_MMIO_EN undefined: no FIFO/counter logic; both addresses unmapped
//   (access_err); uart_valid=0, uart_data=0, uart_ovf=0 constant.
// TESTING
//  1 rst=1 two cycles, release -> rdata=0, access_err=0, err_sticky=0, uart_valid=0.
//  2 write 0x8000_0008 wdata 0x1122_3344_5566_7788 sel 0xFF, read it next cycle
//    -> rdata=0x1122_3344_5566_7788 one cycle after read; access_err stays 0.
//  3 then write same addr wdata 0xAAAA_AAAA_AAAA_AAAA sel 0x0F, read
//    -> rdata=0x1122_3344_AAAA_AAAA; read of 0x8000_000C returns same word.
//  4 read 0x7FFF_FFF8, then write 0x8001_0000 -> rdata=0, access_err pulse each,
//    err_sticky=1 after; read 0x8000_0008 still 0x1122_3344_AAAA_AAAA.
//  5 MMIO_EN, uart_ready=0: write 'H'(0x48),'i'(0x69) then 3 more bytes -> 5th
//    dropped, uart_ovf=1; ready=1 -> drains 0x48,0x69,b3,b4 on consecutive cycles.
//  6 MMIO_EN: read RTC_ADDR at cycle t and t+10 -> values differ by exactly 10;
//    without macro same read -> access_err=1, rdata=0.

Source files
------------

// File: rtl/dsram_responder.sv
`default_nettype none
// dsram_responder: single-port 64-bit data SRAM for the core's dsram_* port, 1-cycle read, byte-masked write (rev 1.0).
// Defining DSRAM_MMIO_EN adds a serial TX FIFO at SERIAL_ADDR and a free-running cycle counter at RTC_ADDR.
module dsram_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 8192,
  parameter logic [63:0] SERIAL_ADDR = 64'hA000_03F8,
  parameter logic [63:0] RTC_ADDR    = 64'hA000_0048,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dsram_e,
  input  logic        dsram_we,
  input  logic [63:0] dsram_addr,
  input  logic [63:0] dsram_wdata,
  input  logic [7:0]  dsram_sel,
  output logic [63:0] dsram_rdata,
  output logic        access_err,
  output logic        err_sticky,
  output logic        uart_valid,
  output logic [7:0]  uart_data,
  input  logic        uart_ready,
  output logic        uart_ovf
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;

  logic [63:0]   aligned;
  logic [63:0]   offset;
  logic [AW-1:0] index;
  logic          ram_hit;
  logic          mmio_hit;
  logic          mapped;
  logic          rd_req;
  logic          wr_req;
  logic [63:0]   mmio_rdata;

  // Full 64-bit range compare, so addresses outside the window never alias into the RAM.
  assign aligned = {dsram_addr[63:3], 3'b000};
  assign offset  = aligned - BASE_ADDR;
  assign index   = offset[AW+2:3];
  assign ram_hit = (aligned >= BASE_ADDR) && (aligned < END_ADDR);
  assign mapped  = ram_hit || mmio_hit;
  assign rd_req  = dsram_e && !dsram_we;
  assign wr_req  = dsram_e && dsram_we;

  logic unused_bits;
  assign unused_bits = ^{dsram_addr[2:0], offset[63:AW+3], offset[2:0]};

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_req && ram_hit) begin
      for (int i = 0; i < 8; i++) begin
        if (dsram_sel[i]) mem[index][8*i +: 8] <= dsram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsram_rdata <= 64'd0;
      access_err  <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      access_err <= dsram_e && !mapped;
      if (dsram_e && !mapped) err_sticky <= 1'b1;
      if (rd_req) dsram_rdata <= ram_hit ? mem[index] : (mmio_hit ? mmio_rdata : 64'd0);
    end
  end

`ifdef DSRAM_MMIO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [63:0]   rtc;
  logic          serial_hit;
  logic          rtc_hit;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_req;
  logic          push;

  assign serial_hit = (aligned == SERIAL_ADDR);
  assign rtc_hit    = (aligned == RTC_ADDR);
  assign mmio_hit   = serial_hit || rtc_hit;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && uart_ready;
  assign push_req   = wr_req && serial_hit && dsram_sel[0];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);
  assign mmio_rdata = serial_hit ? {62'd0, fifo_full, fifo_empty} : rtc;
  assign uart_valid = !fifo_empty;
  assign uart_data  = fifo_empty ? 8'h00 : fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rtc      <= 64'd0;
      uart_ovf <= 1'b0;
    end else begin
      rtc <= rtc + 64'd1;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push) begin
        fifo[wr_ptr] <= dsram_wdata[7:0];
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (push_req && !push) uart_ovf <= 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = 64'd0;
  assign uart_valid = 1'b0;
  assign uart_data  = 8'h00;
  assign uart_ovf   = 1'b0;

  logic [63:0] unused_cfg;
  assign unused_cfg = SERIAL_ADDR ^ RTC_ADDR ^ 64'(FIFO_DEPTH) ^ 64'(uart_ready);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsram_responder.sv
`default_nettype none
// tb_dsram_responder: directed literal checks plus randomized traffic compared every cycle against a behavioural model.
module tb_dsram_responder;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 8192;
  localparam logic [63:0] SER   = 64'hA000_03F8;
  localparam logic [63:0] RTC   = 64'hA000_0048;
  localparam int          FD    = 4;
`ifdef DSRAM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e = 1'b0, we = 1'b0, uart_ready = 1'b0;
  logic [63:0] addr = 64'd0, wdata = 64'd0;
  logic [7:0]  sel = 8'd0;
  logic [63:0] rdata;
  logic        access_err, err_sticky, uart_valid, uart_ovf;
  logic [7:0]  uart_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dsram_responder dut (
    .clk(clk), .rst(rst), .dsram_e(e), .dsram_we(we), .dsram_addr(addr),
    .dsram_wdata(wdata), .dsram_sel(sel), .dsram_rdata(rdata),
    .access_err(access_err), .err_sticky(err_sticky), .uart_valid(uart_valid),
    .uart_data(uart_data), .uart_ready(uart_ready), .uart_ovf(uart_ovf)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: sparse word map, byte queue for the serial FIFO, plain cycle count.
  logic [63:0] m_mem [int];
  logic [7:0]  m_q [$];
  logic [63:0] m_rtc, x_rdata;
  bit          x_known, x_err, x_sticky, x_ovf;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    logic [63:0] a, w;
    bit ram, ser, rt, mapped, do_pop;
    int idx;
    if (rst) begin
      x_rdata = 64'd0; x_known = 1'b1; x_err = 1'b0; x_sticky = 1'b0; x_ovf = 1'b0;
      m_q.delete(); m_rtc = 64'd0; m_live = 1'b1;
    end else if (m_live) begin
      a      = addr & ~64'h7;
      ram    = (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
      ser    = MMIO && (a == SER);
      rt     = MMIO && (a == RTC);
      mapped = ram || ser || rt;
      idx    = int'((a - BASE) >> 3);
      do_pop = (m_q.size() > 0) && uart_ready;
      x_err  = e && !mapped;
      if (x_err) x_sticky = 1'b1;
      if (e && !we) begin
        x_known = 1'b1;
        if (ram) begin
          x_known = m_mem.exists(idx);
          x_rdata = x_known ? m_mem[idx] : 64'd0;
        end else if (ser) x_rdata = {62'd0, m_q.size() == FD, m_q.size() == 0};
        else if (rt) x_rdata = m_rtc;
        else x_rdata = 64'd0;
      end
      if (e && we && ram && (m_mem.exists(idx) || sel == 8'hFF)) begin
        w = m_mem.exists(idx) ? m_mem[idx] : 64'd0;
        for (int i = 0; i < 8; i++) if (sel[i]) w[8*i +: 8] = wdata[8*i +: 8];
        m_mem[idx] = w;
      end
      if (do_pop) void'(m_q.pop_front());
      if (e && we && ser && sel[0]) begin
        if (m_q.size() < FD) m_q.push_back(wdata[7:0]);
        else x_ovf = 1'b1;
      end
      m_rtc = m_rtc + 64'd1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      if (x_known) chk("rdata", rdata, x_rdata);
      chk("access_err", 64'(access_err), 64'(x_err));
      chk("err_sticky", 64'(err_sticky), 64'(x_sticky));
      chk("uart_valid", 64'(uart_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) chk("uart_data", 64'(uart_data), 64'(m_q[0]));
      chk("uart_ovf", 64'(uart_ovf), 64'(x_ovf));
    end
  end

  task automatic drive(input bit ie, input bit iwe, input logic [63:0] ia,
                       input logic [63:0] iwd, input logic [7:0] is);
    @(posedge clk); #2;
    e = ie; we = iwe; addr = ia; wdata = iwd; sel = is;
  endtask

  task automatic settle();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
    @(negedge clk);
  endtask

  function automatic logic [63:0] pool_addr(input int k);
    return BASE + 64'((k < 16) ? k : DEPTH - 20 + k) * 64'd8;
  endfunction

  initial begin
    logic [63:0] bad [5];
    logic [63:0] v1, v2, a;
    int r;
    bad[0] = BASE - 64'd8;
    bad[1] = BASE + 64'(DEPTH) * 64'd8;
    bad[2] = 64'd0;
    bad[3] = 64'hFFFF_FFFF_FFFF_FFF8;
    bad[4] = BASE + (64'd1 << 40) + 64'd8;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset rdata", rdata, 64'd0);
    chk("reset access_err", 64'(access_err), 64'd0);
    chk("reset err_sticky", 64'(err_sticky), 64'd0);
    chk("reset uart_valid", 64'(uart_valid), 64'd0);
    chk("reset uart_data", 64'(uart_data), 64'd0);
    chk("reset uart_ovf", 64'(uart_ovf), 64'd0);

    drive(1, 1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
    drive(1, 0, 64'h8000_0008, 64'd0, 8'h00);
    settle();
    chk("full write readback", rdata, 64'h1122_3344_5566_7788);
    chk("full write no err", 64'(access_err), 64'd0);

    drive(1, 1, 64'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    drive(1, 0, 64'h8000_0008, 64'd0, 8'h00);
    settle();
    chk("masked write readback", rdata, 64'h1122_3344_AAAA_AAAA);
    drive(1, 0, 64'h8000_000C, 64'd0, 8'h00);
    settle();
    chk("unaligned read same word", rdata, 64'h1122_3344_AAAA_AAAA);

    drive(1, 0, 64'h7FFF_FFF8, 64'd0, 8'h00);
    settle();
    chk("below-base read rdata", rdata, 64'd0);
    chk("below-base read err", 64'(access_err), 64'd1);
    drive(1, 1, 64'h8001_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    settle();
    chk("past-end write err", 64'(access_err), 64'd1);
    chk("err_sticky set", 64'(err_sticky), 64'd1);
    drive(1, 0, 64'h8000_0008, 64'd0, 8'h00);
    settle();
    chk("ram intact after bad write", rdata, 64'h1122_3344_AAAA_AAAA);
    chk("err pulse cleared", 64'(access_err), 64'd0);
    chk("err_sticky held", 64'(err_sticky), 64'd1);

`ifdef DSRAM_MMIO_EN
    drive(1, 1, SER, 64'h48, 8'h01);
    drive(1, 1, SER, 64'h69, 8'h01);
    drive(1, 1, SER, 64'h33, 8'h01);
    drive(1, 1, SER, 64'h44, 8'h01);
    drive(1, 1, SER, 64'h55, 8'h01);
    settle();
    chk("fifo overflow flag", 64'(uart_ovf), 64'd1);
    chk("fifo head valid", 64'(uart_valid), 64'd1);
    @(posedge clk); #2 uart_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v1 = (i == 0) ? 64'h48 : (i == 1) ? 64'h69 : (i == 2) ? 64'h33 : 64'h44;
      chk("drain byte", 64'(uart_data), v1);
      chk("drain valid", 64'(uart_valid), 64'd1);
    end
    @(negedge clk);
    chk("drained empty", 64'(uart_valid), 64'd0);

    drive(1, 0, RTC, 64'd0, 8'h00);
    settle();
    v1 = rdata;
    repeat (8) drive(0, 0, 64'd0, 64'd0, 8'h00);
    drive(1, 0, RTC, 64'd0, 8'h00);
    settle();
    v2 = rdata;
    chk("rtc delta 10", v2 - v1, 64'd10);
    chk("rtc read no err", 64'(access_err), 64'd0);
`else
    drive(1, 0, RTC, 64'd0, 8'h00);
    settle();
    chk("rtc unmapped err", 64'(access_err), 64'd1);
    chk("rtc unmapped rdata", rdata, 64'd0);
`endif

    for (int k = 0; k < 20; k++)
      drive(1, 1, pool_addr(k), {$urandom, $urandom}, 8'hFF);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        drive(0, 0, 64'd0, 64'd0, 8'h00);
        rst = 1'b1;
        repeat (2) drive(0, 0, 64'd0, 64'd0, 8'h00);
        rst = 1'b0;
      end
      r = $urandom_range(0, 99);
      if (r < 35)      drive(1, 0, pool_addr($urandom_range(0, 19)) | 64'($urandom_range(0, 7)), 64'd0, 8'h00);
      else if (r < 65) drive(1, 1, pool_addr($urandom_range(0, 19)), {$urandom, $urandom}, 8'($urandom));
      else if (r < 72) begin
        a = bad[$urandom_range(0, 4)];
        drive(1, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom));
      end
      else if (r < 85) drive(1, 1, SER | 64'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom) | 8'($urandom_range(0, 1)));
      else if (r < 90) drive(1, 0, SER, 64'd0, 8'h00);
      else if (r < 95) drive(1, 1'($urandom_range(0, 1)), RTC, {$urandom, $urandom}, 8'hFF);
      else             drive(0, 0, 64'd0, 64'd0, 8'h00);
      uart_ready = ($urandom_range(0, 3) == 0);
    end
    settle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
